// File: rtl/uart_transceiver_if.sv
// Parallel-side bundle of the 8N1 UART: TX request/status, RX data/strobe, and both serial pins.
// Signal prefixes are from the UART's point of view (slave modport).
interface uart_transceiver_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;

    modport slave (
        input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );

    modport master (
        output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );
endinterface

// File: rtl/uart_transceiver.sv
// 8N1 UART with independent transmitter and receiver sharing one clock and reset.
// Fixed baud: CLKS_PER_BIT clocks per bit; receiver samples at mid-bit after a 2-flop synchronizer.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic               i_Clock,
    input  logic               i_Resetn,
    uart_transceiver_if.slave  io_uart
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    // ---------------- transmitter ----------------
    state_t        r_tx_state,  w_tx_state_next;
    logic [CW-1:0] r_tx_cnt,    w_tx_cnt_next;
    logic [2:0]    r_tx_idx,    w_tx_idx_next;
    logic [7:0]    r_tx_data,   w_tx_data_next;
    logic          r_tx_serial, w_tx_serial_next;
    logic          r_tx_active, w_tx_active_next;
    logic          r_tx_done,   w_tx_done_next;
    logic [2:0]    w_tx_idx_inc;

    assign w_tx_idx_inc = r_tx_idx + 3'd1;

    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_tx_state  <= S_IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_tx_data   <= '0;
            r_tx_serial <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_state  <= w_tx_state_next;
            r_tx_cnt    <= w_tx_cnt_next;
            r_tx_idx    <= w_tx_idx_next;
            r_tx_data   <= w_tx_data_next;
            r_tx_serial <= w_tx_serial_next;
            r_tx_active <= w_tx_active_next;
            r_tx_done   <= w_tx_done_next;
        end
    end

    // The serial output is registered, so each state loads the level for the bit that starts next.
    always_comb begin
        w_tx_state_next  = r_tx_state;
        w_tx_cnt_next    = r_tx_cnt;
        w_tx_idx_next    = r_tx_idx;
        w_tx_data_next   = r_tx_data;
        w_tx_serial_next = r_tx_serial;
        w_tx_active_next = r_tx_active;
        w_tx_done_next   = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_serial_next = 1'b1;
                w_tx_cnt_next    = '0;
                w_tx_idx_next    = '0;
                if (io_uart.i_Tx_DV) begin
                    w_tx_data_next   = io_uart.i_Tx_Byte;
                    w_tx_active_next = 1'b1;
                    w_tx_serial_next = 1'b0;
                    w_tx_state_next  = S_START;
                end
            end
            S_START: begin
                if (r_tx_cnt == LAST_CNT) begin
                    w_tx_cnt_next    = '0;
                    w_tx_serial_next = r_tx_data[0];
                    w_tx_state_next  = S_DATA;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_tx_cnt == LAST_CNT) begin
                    w_tx_cnt_next = '0;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_idx_next    = '0;
                        w_tx_serial_next = 1'b1;
                        w_tx_state_next  = S_STOP;
                    end else begin
                        w_tx_idx_next    = w_tx_idx_inc;
                        w_tx_serial_next = r_tx_data[w_tx_idx_inc];
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_tx_cnt == LAST_CNT) begin
                    w_tx_cnt_next    = '0;
                    w_tx_done_next   = 1'b1;
                    w_tx_active_next = 1'b0;
                    w_tx_state_next  = S_CLEANUP;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            S_CLEANUP: w_tx_state_next = S_IDLE;
            default:   w_tx_state_next = S_IDLE;
        endcase
    end

    assign io_uart.o_Tx_Serial = r_tx_serial;
    assign io_uart.o_Tx_Active = r_tx_active;
    assign io_uart.o_Tx_Done   = r_tx_done;

    // ---------------- receiver ----------------
    logic          r_rx_sync1, r_rx_sync2;
    logic          w_rx_line;
    state_t        r_rx_state, w_rx_state_next;
    logic [CW-1:0] r_rx_cnt,   w_rx_cnt_next;
    logic [2:0]    r_rx_idx,   w_rx_idx_next;
    logic [7:0]    r_rx_shift, w_rx_shift_next;
    logic [7:0]    r_rx_byte,  w_rx_byte_next;
    logic          r_rx_dv,    w_rx_dv_next;
    logic          r_rx_armed, w_rx_armed_next;

    assign w_rx_line = r_rx_sync2;

    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_dv    <= 1'b0;
            r_rx_armed <= 1'b0;
        end else begin
            r_rx_sync1 <= io_uart.i_Rx_Serial;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_idx   <= w_rx_idx_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_byte  <= w_rx_byte_next;
            r_rx_dv    <= w_rx_dv_next;
            r_rx_armed <= w_rx_armed_next;
        end
    end

    // A start is only accepted after the line has been seen high in IDLE, so a stuck-low
    // line following a framing error cannot retrigger reception.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_idx_next   = r_rx_idx;
        w_rx_shift_next = r_rx_shift;
        w_rx_byte_next  = r_rx_byte;
        w_rx_armed_next = r_rx_armed;
        w_rx_dv_next    = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_next = '0;
                w_rx_idx_next = '0;
                if (w_rx_line) begin
                    w_rx_armed_next = 1'b1;
                end else if (r_rx_armed) begin
                    w_rx_armed_next = 1'b0;
                    w_rx_state_next = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == MID_CNT) begin
                    w_rx_cnt_next   = '0;
                    w_rx_state_next = w_rx_line ? S_IDLE : S_DATA;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == LAST_CNT) begin
                    w_rx_cnt_next             = '0;
                    w_rx_shift_next[r_rx_idx] = w_rx_line;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_idx_next   = '0;
                        w_rx_state_next = S_STOP;
                    end else begin
                        w_rx_idx_next = r_rx_idx + 3'd1;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == LAST_CNT) begin
                    w_rx_cnt_next   = '0;
                    w_rx_state_next = S_CLEANUP;
                    if (w_rx_line) begin
                        w_rx_byte_next = r_rx_shift;
                        w_rx_dv_next   = 1'b1;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            S_CLEANUP: w_rx_state_next = S_IDLE;
            default:   w_rx_state_next = S_IDLE;
        endcase
    end

    assign io_uart.o_Rx_DV   = r_rx_dv;
    assign io_uart.o_Rx_Byte = r_rx_byte;

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: directed + random TX/RX frames against a frame-level model,
// plus a loopback instance at the default baud divisor.
module tb_uart_transceiver;

    localparam int CPB    = 8;
    localparam int CPB_LB = 234;
    localparam int FRAME  = 10 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_transceiver_if u_if ();
    uart_transceiver_if lb_if ();

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock  (clk),
        .i_Resetn (rst_n),
        .io_uart  (u_if)
    );

    uart_transceiver #(.CLKS_PER_BIT(CPB_LB)) dut_lb (
        .i_Clock  (clk),
        .i_Resetn (rst_n),
        .io_uart  (lb_if)
    );

    assign lb_if.i_Rx_Serial = lb_if.o_Tx_Serial;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] lb_q[$];

    always @(negedge clk) begin
        if (u_if.o_Rx_DV === 1'b1) begin
            rx_q.push_back(u_if.o_Rx_Byte);
            rx_t.push_back(cyc);
        end
        if (lb_if.o_Rx_DV === 1'b1) lb_q.push_back(lb_if.o_Rx_Byte);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one byte and check every cycle of the frame; optionally fire a second DV at cycle busy_at.
    task automatic tx_frame(input logic [7:0] b, input int busy_at, input logic [7:0] busy_b);
        logic [9:0] frame;
        logic       exp_ser, exp_act, exp_done;
        int         errs_before;
        errs_before = errors;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        u_if.i_Tx_Byte = b;
        u_if.i_Tx_DV   = 1'b1;
        @(negedge clk);
        u_if.i_Tx_DV   = 1'b0;
        for (int c = 0; c < FRAME + 3; c++) begin
            if (c < FRAME) begin
                exp_ser = frame[c / CPB]; exp_act = 1'b1; exp_done = 1'b0;
            end else if (c == FRAME) begin
                exp_ser = 1'b1; exp_act = 1'b0; exp_done = 1'b1;
            end else begin
                exp_ser = 1'b1; exp_act = 1'b0; exp_done = 1'b0;
            end
            chk($sformatf("tx_serial_%02h_c%0d", b, c), u_if.o_Tx_Serial, exp_ser);
            chk($sformatf("tx_active_%02h_c%0d", b, c), u_if.o_Tx_Active, exp_act);
            chk($sformatf("tx_done_%02h_c%0d", b, c), u_if.o_Tx_Done, exp_done);
            u_if.i_Tx_DV = (c == busy_at);
            if (c == busy_at) u_if.i_Tx_Byte = busy_b;
            @(negedge clk);
        end
        u_if.i_Tx_DV = 1'b0;
        $display("TX byte=%02h busy_dv_at=%0d errors_in_frame=%0d", b, busy_at, errors - errs_before);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            u_if.i_Rx_Serial = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        u_if.i_Rx_Serial = 1'b1;
    endtask

    // Good frame: one DV, correct byte, DV 2-3 cycles after mid-stop (mid-stop = t0 + 9.5*CPB).
    task automatic rx_expect(input string tag, input logic [7:0] b, input int t0);
        int d;
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_dv_count"}, rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            d = rx_t[0] - t0;
            chk({tag, "_byte"}, rx_q[0], b);
            chk({tag, "_dv_timing_ok"}, (d >= (19 * CPB) / 2 + 2) && (d <= (19 * CPB) / 2 + 3), 1);
        end
        chk({tag, "_held_byte"}, u_if.o_Rx_Byte, b);
        $display("RX byte=%02h dv_seen=%0d", b, rx_q.size());
        rx_q.delete();
        rx_t.delete();
    endtask

    logic [7:0] last_rx;
    logic [7:0] rb;
    logic [7:0] lb_bytes[3];
    int         t0;
    int         n;

    initial begin
        rst_n            = 1'b0;
        u_if.i_Tx_DV     = 1'b0;
        u_if.i_Tx_Byte   = 8'h00;
        u_if.i_Rx_Serial = 1'b1;
        lb_if.i_Tx_DV    = 1'b0;
        lb_if.i_Tx_Byte  = 8'h00;
        lb_bytes[0] = 8'h00; lb_bytes[1] = 8'h55; lb_bytes[2] = 8'hFF;

        #12;
        chk("rst_tx_serial", u_if.o_Tx_Serial, 1);
        chk("rst_tx_active", u_if.o_Tx_Active, 0);
        chk("rst_tx_done",   u_if.o_Tx_Done,   0);
        chk("rst_rx_dv",     u_if.o_Rx_DV,     0);
        chk("rst_rx_byte",   u_if.o_Rx_Byte,   8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // TX: busy DV mid-frame ignored; DV during cleanup ignored; then random bytes
        tx_frame(8'hA5, 20, 8'h3C);
        tx_frame(8'h3C, FRAME, 8'h99);
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom_range(0, 255));
            tx_frame(rb, int'($urandom_range(1, FRAME - 1)), 8'($urandom_range(0, 255)));
        end

        // RX: directed then random good frames
        rx_frame(8'h5A, 1'b1, t0); rx_expect("rx_5a", 8'h5A, t0);
        repeat (5) @(posedge clk);
        rx_frame(8'hFF, 1'b1, t0); rx_expect("rx_ff", 8'hFF, t0);
        last_rx = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(2, 15)) @(posedge clk);
            #1;
            chk("rx_hold_between", u_if.o_Rx_Byte, last_rx);
            rb = 8'($urandom_range(0, 255));
            rx_frame(rb, 1'b1, t0);
            rx_expect("rx_rand", rb, t0);
            last_rx = rb;
        end

        // Short glitch: no DV
        @(posedge clk); #1;
        u_if.i_Rx_Serial = 1'b0;
        repeat (2) @(posedge clk); #1;
        u_if.i_Rx_Serial = 1'b1;
        repeat (30) @(posedge clk); #1;
        chk("rx_glitch_no_dv", rx_q.size(), 0);
        chk("rx_glitch_byte",  u_if.o_Rx_Byte, last_rx);
        $display("RX glitch dv_seen=%0d", rx_q.size());

        // Framing error: no DV, byte unchanged
        rx_frame(8'h81, 1'b0, t0);
        repeat (30) @(posedge clk); #1;
        chk("rx_frame_err_no_dv", rx_q.size(), 0);
        chk("rx_frame_err_byte",  u_if.o_Rx_Byte, last_rx);
        $display("RX framing-error byte=81 dv_seen=%0d", rx_q.size());
        rx_q.delete(); rx_t.delete();

        rx_frame(8'h42, 1'b1, t0); rx_expect("rx_42", 8'h42, t0);

        // Asynchronous reset mid-TX frame (data bit 1 of 0x00 is low at cycle 20)
        @(negedge clk);
        u_if.i_Tx_Byte = 8'h00;
        u_if.i_Tx_DV   = 1'b1;
        @(negedge clk);
        u_if.i_Tx_DV   = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_pre_active", u_if.o_Tx_Active, 1);
        chk("midrst_pre_serial", u_if.o_Tx_Serial, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_serial", u_if.o_Tx_Serial, 1);
        chk("midrst_tx_active", u_if.o_Tx_Active, 0);
        chk("midrst_rx_dv",     u_if.o_Rx_DV,     0);
        chk("midrst_rx_byte",   u_if.o_Rx_Byte,   8'h00);
        $display("RESET mid-frame serial=%0b active=%0b rx_byte=%02h",
                 u_if.o_Tx_Serial, u_if.o_Tx_Active, u_if.o_Rx_Byte);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Loopback at the default divisor
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lb_if.i_Tx_Byte = lb_bytes[k];
            lb_if.i_Tx_DV   = 1'b1;
            @(negedge clk);
            lb_if.i_Tx_DV   = 1'b0;
            n = 0;
            while (lb_if.o_Tx_Active === 1'b1 && n < 12 * CPB_LB) begin
                @(negedge clk);
                n++;
            end
            chk("lb_tx_frame_len", n, 10 * CPB_LB);
            $display("LB TX byte=%02h active_cycles=%0d", lb_bytes[k], n);
        end
        n = 0;
        while (lb_q.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("lb_rx_count", lb_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < lb_q.size()) begin
                chk($sformatf("lb_rx_byte%0d", k), lb_q[k], lb_bytes[k]);
                $display("LB RX byte=%02h expected=%02h", lb_q[k], lb_bytes[k]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
